hcms29xx_rx: RTL and testbench

- Receive-side counterpart of the HCMS29xx display driver: a synthesizable emulator of the HCMS-29xx serial input port.
- Oversamples the 5-wire display bus (rst_n, clk, din, rs, ce_n) on a fast local clock.
- Shifts dot and control bits per device semantics and presents the latched frame plus control words in parallel.
- Used as a loopback checker for the driver and to mirror the panel onto another display or a logic analyser.

---
 rtl/hcms29xx_pkg.sv | 34 +++
 rtl/hcms29xx_rx_sync_edge.sv | 36 +++
 rtl/hcms29xx_rx.sv | 144 ++++++++++++++
 tb/tb_hcms29xx_rx.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hcms29xx_pkg.sv
// Shared definitions for the HCMS-29xx serial-port receiver: FSM encoding,
// control-word field positions, frame sizing and the driver's din mux codes.
package hcms29xx_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      SH_DATA = 2'b01,
      SH_CMD  = 2'b10
   } state_t;

   // Control-word layout; bit 7 selects which word the load targets.
   localparam int CW_BITS  = 8;
   localparam int CW_SEL   = 7;
   localparam int CW0_S    = 6;
   localparam int CW0_I_HI = 5;
   localparam int CW0_I_LO = 4;
   localparam int CW0_P_HI = 3;
   localparam int CW0_P_LO = 0;
   localparam int CW1_O    = 1;
   localparam int CW1_D    = 0;

   // What the driver places on din; kept here so both ends agree.
   typedef enum logic [1:0] {
      SSDM_DOT = 2'b00,
      SSDM_CW0 = 2'b01,
      SSDM_CW1 = 2'b10
   } ssdm_t;

   // Dot register length of a chain of n units, w columns by h rows each.
   function automatic int frame_bits(input int n, input int w, input int h);
      return n * w * h;
   endfunction

endpackage

// File: rtl/hcms29xx_rx_sync_edge.sv
// Synchroniser for one asynchronous bus pin followed by a registered edge
// detector. level is the synchronised value aligned with rise/fall, so a
// consumer sees the edge and the matching level in the same cycle.
module hcms29xx_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   last;

   // Sync chain, one-cycle history and registered edge strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         last   <= RST_VAL;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
         last   <= sync_q[SYNC_STAGES-1];
         rise   <= sync_q[SYNC_STAGES-1] & ~last;
         fall   <= ~sync_q[SYNC_STAGES-1] & last;
      end
   end

   assign level = last;

endmodule

// File: rtl/hcms29xx_rx.sv
// Emulates the HCMS-29xx serial input port on a fast local clock: samples
// the five bus wires, shifts dot or control bits and presents the latched
// dot image and control words in parallel.
//
// state   | meaning
// IDLE    | ce_n high (or aborted); bus clocks ignored
// SH_DATA | ce_n low, rs was 0 at ce_n fall; shifting the dot register
// SH_CMD  | ce_n low, rs was 1 at ce_n fall; shifting the control register
module hcms29xx_rx
   import hcms29xx_pkg::*;
#(
   parameter int N           = 2,
   parameter int UNIT_W      = 20,
   parameter int UNIT_H      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_rst_n,
   input  logic                         s_clk,
   input  logic                         s_din,
   input  logic                         s_rs,
   input  logic                         s_ce_n,
   output logic [N*UNIT_W*UNIT_H-1:0]   frame_o,
   output logic [6:0]                   cw0_o,
   output logic [1:0]                   cw1_o,
   output logic                         frame_vld_o,
   output logic                         cw_vld_o,
   output logic                         err_len_o,
   output logic                         err_proto_o,
   output logic                         busy_o
);

   localparam int FB    = frame_bits(N, UNIT_W, UNIT_H);
   localparam int CNT_W = $clog2(FB + 2);

   localparam logic [CNT_W-1:0] DATA_FULL = CNT_W'(FB);
   localparam logic [CNT_W-1:0] DATA_SAT  = CNT_W'(FB + 1);
   localparam logic [CNT_W-1:0] CMD_FULL  = CNT_W'(CW_BITS);
   localparam logic [CNT_W-1:0] CMD_SAT   = CNT_W'(CW_BITS + 1);

   logic rstn_lvl, rstn_rise, rstn_fall;
   logic sclk_lvl, sclk_rise, sclk_fall;
   logic din_lvl,  din_rise,  din_fall;
   logic rs_lvl,   rs_rise,   rs_fall;
   logic ce_lvl,   ce_rise,   ce_fall;
   logic unused_edges;

   hcms29xx_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rstn (
      .clk(clk), .rst(rst), .d(s_rst_n),
      .level(rstn_lvl), .rise(rstn_rise), .fall(rstn_fall));

   hcms29xx_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .d(s_clk),
      .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));

   hcms29xx_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
      .clk(clk), .rst(rst), .d(s_din),
      .level(din_lvl), .rise(din_rise), .fall(din_fall));

   hcms29xx_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_rs (
      .clk(clk), .rst(rst), .d(s_rs),
      .level(rs_lvl), .rise(rs_rise), .fall(rs_fall));

   hcms29xx_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ce (
      .clk(clk), .rst(rst), .d(s_ce_n),
      .level(ce_lvl), .rise(ce_rise), .fall(ce_fall));

   assign unused_edges = ^{rstn_rise, rstn_fall, sclk_lvl, sclk_fall,
                           din_rise, din_fall, ce_lvl};

   state_t             state;
   logic [FB-1:0]      sh_data;
   logic [CW_BITS-1:0] sh_cmd;
   logic [CNT_W-1:0]   bit_cnt;
   logic               rs_tog;

   assign rs_tog = rs_rise | rs_fall;
   assign busy_o = (state != IDLE);

   // Load sequencer: mode chosen at ce_n fall, bits shifted on s_clk rise,
   // commit at ce_n rise. A ce_n rise outranks a coincident s_clk rise.
   always_ff @(posedge clk) begin
      if (rst || !rstn_lvl) begin
         state       <= IDLE;
         sh_data     <= '0;
         sh_cmd      <= '0;
         bit_cnt     <= '0;
         frame_o     <= '0;
         cw0_o       <= '0;
         cw1_o       <= '0;
         frame_vld_o <= 1'b0;
         cw_vld_o    <= 1'b0;
         err_len_o   <= 1'b0;
         err_proto_o <= 1'b0;
      end else begin
         frame_vld_o <= 1'b0;
         cw_vld_o    <= 1'b0;
         err_len_o   <= 1'b0;
         err_proto_o <= 1'b0;
         case (state)
            IDLE: begin
               if (ce_fall) begin
                  sh_data <= '0;
                  sh_cmd  <= '0;
                  bit_cnt <= '0;
                  state   <= rs_lvl ? SH_CMD : SH_DATA;
               end
            end
            SH_DATA: begin
               err_proto_o <= rs_tog;
               if (ce_rise) begin
                  state <= IDLE;
                  if (bit_cnt != '0) begin
                     frame_o     <= sh_data;
                     frame_vld_o <= 1'b1;
                     err_len_o   <= (bit_cnt != DATA_FULL);
                  end
               end else if (sclk_rise) begin
                  sh_data <= {din_lvl, sh_data[FB-1:1]};
                  if (bit_cnt != DATA_SAT) bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
            SH_CMD: begin
               err_proto_o <= rs_tog;
               if (ce_rise) begin
                  state <= IDLE;
                  if (bit_cnt != '0) begin
                     if (sh_cmd[CW_SEL]) cw1_o <= {sh_cmd[CW1_O], sh_cmd[CW1_D]};
                     else                cw0_o <= sh_cmd[CW0_S:CW0_P_LO];
                     cw_vld_o  <= 1'b1;
                     err_len_o <= (bit_cnt != CMD_FULL);
                  end
               end else if (sclk_rise) begin
                  sh_cmd <= {din_lvl, sh_cmd[CW_BITS-1:1]};
                  if (bit_cnt != CMD_SAT) bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hcms29xx_rx.sv
// Bench for hcms29xx_rx: drives the 5-wire bus at clk/8 and checks commits
// against a reference model through an expectation queue.
module tb_hcms29xx_rx;

   localparam int N      = 2;
   localparam int UNIT_W = 20;
   localparam int UNIT_H = 8;
   localparam int SS     = 2;
   localparam int FB     = N * UNIT_W * UNIT_H;

   logic clk = 1'b0, rst = 1'b1;
   logic s_rst_n = 1'b1, s_clk = 1'b0, s_din = 1'b0, s_rs = 1'b0, s_ce_n = 1'b1;
   logic [FB-1:0] frame_o;
   logic [6:0]    cw0_o;
   logic [1:0]    cw1_o;
   logic          frame_vld_o, cw_vld_o, err_len_o, err_proto_o, busy_o;

   always #5 clk = ~clk;

   hcms29xx_rx #(.N(N), .UNIT_W(UNIT_W), .UNIT_H(UNIT_H), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst(rst), .s_rst_n(s_rst_n), .s_clk(s_clk), .s_din(s_din),
      .s_rs(s_rs), .s_ce_n(s_ce_n), .frame_o(frame_o), .cw0_o(cw0_o),
      .cw1_o(cw1_o), .frame_vld_o(frame_vld_o), .cw_vld_o(cw_vld_o),
      .err_len_o(err_len_o), .err_proto_o(err_proto_o), .busy_o(busy_o));

   typedef enum int {K_PROTO, K_FRAME, K_CW} kind_t;
   typedef struct {
      kind_t         kind;
      logic [FB-1:0] frame;
      logic [6:0]    cw0;
      logic [1:0]    cw1;
      logic          err_len;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          mon_e;
   logic          bits_q[$];
   logic [FB-1:0] m_frame = '0;
   logic [6:0]    m_cw0 = '0;
   logic [1:0]    m_cw1 = '0;
   int            tests = 0, fails = 0;
   bit            mon_en = 1'b0;
   int            lat;

   // Scoreboard: every output pulse must match the head of the queue.
   always @(negedge clk) begin
      if (mon_en) begin
         if (err_proto_o) begin
            tests++;
            if (exp_q.size() == 0 || exp_q[0].kind != K_PROTO) begin
               fails++;
               $display("FAIL proto_pulse: got err_proto_o=1, required none (queue %0d)", exp_q.size());
            end else void'(exp_q.pop_front());
         end
         if (frame_vld_o || cw_vld_o) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL commit_unexpected: got frame_vld=%b cw_vld=%b, required none", frame_vld_o, cw_vld_o);
            end else begin
               mon_e = exp_q.pop_front();
               if (frame_vld_o !== (mon_e.kind == K_FRAME) || cw_vld_o !== (mon_e.kind == K_CW) ||
                   frame_o !== mon_e.frame || cw0_o !== mon_e.cw0 || cw1_o !== mon_e.cw1 ||
                   err_len_o !== mon_e.err_len) begin
                  fails++;
                  $display("FAIL commit: got fv=%b cv=%b len=%b cw0=%h cw1=%h frame=%h required fv=%b cv=%b len=%b cw0=%h cw1=%h frame=%h",
                           frame_vld_o, cw_vld_o, err_len_o, cw0_o, cw1_o, frame_o,
                           mon_e.kind == K_FRAME, mon_e.kind == K_CW, mon_e.err_len,
                           mon_e.cw0, mon_e.cw1, mon_e.frame);
               end
            end
         end else if (err_len_o) begin
            tests++;
            fails++;
            $display("FAIL err_len_alone: got err_len_o=1 without a valid pulse, required 0");
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete, required finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_bit(input logic b);
      s_din = b;
      wait_clk(4);
      s_clk = 1'b1;
      wait_clk(4);
      s_clk = 1'b0;
   endtask

   task automatic fill_byte(input logic [7:0] v);
      for (int k = 0; k < 8; k++) bits_q.push_back(v[k]);
   endtask

   task automatic fill_pattern(input int n);
      for (int k = 0; k < n; k++) bits_q.push_back((k % 3) == 0);
   endtask

   task automatic ce_high(output int l);
      l = 0;
      s_ce_n = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (l == 0 && (frame_vld_o || cw_vld_o)) l = c;
      end
      wait_clk(2);
   endtask

   task automatic push_proto();
      exp_t p;
      p.kind = K_PROTO; p.frame = '0; p.cw0 = '0; p.cw1 = '0; p.err_len = 1'b0;
      exp_q.push_back(p);
   endtask

   // Reference: the register keeps the last w bits sent, first-sent lowest.
   task automatic model_commit(input logic mode);
      int            n, w, idx;
      logic [FB-1:0] v;
      exp_t          e;
      n = bits_q.size();
      w = mode ? 8 : FB;
      v = '0;
      if (n == 0) return;
      for (int i = 0; i < w; i++) begin
         idx = (n >= w) ? n - w + i : i - (w - n);
         if (idx >= 0) v[i] = bits_q[idx];
      end
      e.err_len = (n != w);
      if (!mode) begin
         m_frame = v;
         e.kind  = K_FRAME;
      end else begin
         if (v[7]) m_cw1 = v[1:0];
         else      m_cw0 = v[6:0];
         e.kind = K_CW;
      end
      e.frame = m_frame; e.cw0 = m_cw0; e.cw1 = m_cw1;
      exp_q.push_back(e);
   endtask

   task automatic run_load(input logic rs, input int toggle_at, output int l);
      s_rs = rs;
      wait_clk(4);
      s_ce_n = 1'b0;
      wait_clk(4);
      for (int k = 0; k < bits_q.size(); k++) begin
         if (k == toggle_at) begin
            push_proto();
            s_rs = ~s_rs;
            wait_clk(4);
         end
         bus_bit(bits_q[k]);
      end
      model_commit(rs);
      ce_high(l);
      wait_clk(4);
      bits_q.delete();
   endtask

   task automatic check_drain(input string name);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s_drain: got %0d pending expectations, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_lat(input string name, input int l);
      tests++;
      if (l != SS + 2) begin
         fails++;
         $display("FAIL %s_latency: got %0d cycles, required %0d", name, l, SS + 2);
      end
   endtask

   task automatic check_cleared(input string name);
      tests++;
      if (frame_o !== '0 || cw0_o !== 7'h0 || cw1_o !== 2'b0 || busy_o !== 1'b0) begin
         fails++;
         $display("FAIL %s: got cw0=%h cw1=%h busy=%b frame=%h, required all zero",
                  name, cw0_o, cw1_o, busy_o, frame_o);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wait_clk(4);
      rst = 1'b0;
      wait_clk(4);
      mon_en = 1'b1;
      check_cleared("reset_rst");
      s_rst_n = 1'b0;
      wait_clk(32);
      tests++;
      if (busy_o !== 1'b0) begin
         fails++;
         $display("FAIL reset_busy: got %b, required 0", busy_o);
      end
      s_rst_n = 1'b1;
      wait_clk(8);
      check_cleared("reset_s_rst_n");
      check_drain("reset");
   endtask

   task automatic test_cw();
      fill_byte(8'h4F);
      run_load(1'b1, -1, lat);
      check_lat("cw0", lat);
      tests++;
      if (cw0_o !== 7'h4F) begin
         fails++;
         $display("FAIL cw0_value: got %h, required 4f", cw0_o);
      end
      fill_byte(8'h81);
      run_load(1'b1, -1, lat);
      tests++;
      if (cw1_o !== 2'b01 || cw0_o !== 7'h4F) begin
         fails++;
         $display("FAIL cw1_value: got cw1=%b cw0=%h, required cw1=01 cw0=4f", cw1_o, cw0_o);
      end
      check_drain("cw");
   endtask

   task automatic test_data();
      fill_pattern(FB);
      run_load(1'b0, -1, lat);
      check_lat("data", lat);
      tests++;
      if (frame_o !== m_frame) begin
         fails++;
         $display("FAIL data_frame: got %h, required %h", frame_o, m_frame);
      end
      check_drain("data");
   endtask

   task automatic test_len();
      fill_pattern(FB - 1);
      run_load(1'b0, -1, lat);
      fill_pattern(FB + 5);
      run_load(1'b0, -1, lat);
      check_drain("len");
   endtask

   task automatic test_zero();
      s_rs = 1'b0;
      wait_clk(4);
      s_ce_n = 1'b0;
      wait_clk(8);
      ce_high(lat);
      tests++;
      if (lat != 0) begin
         fails++;
         $display("FAIL zero_load: got commit after %0d cycles, required none", lat);
      end
      check_drain("zero");
   endtask

   task automatic test_proto();
      fill_pattern(FB);
      run_load(1'b0, 160, lat);
      fill_byte(8'h3C);
      fill_pattern(FB);
      run_load(1'b1, 8, lat);
      check_drain("proto");
   endtask

   task automatic test_abort(input bit use_rst);
      fill_pattern(FB);
      s_rs = 1'b0;
      wait_clk(4);
      s_ce_n = 1'b0;
      wait_clk(4);
      for (int k = 0; k < 150; k++) bus_bit(bits_q[k]);
      bits_q.delete();
      tests++;
      if (busy_o !== 1'b1) begin
         fails++;
         $display("FAIL abort_busy_mid: got %b, required 1", busy_o);
      end
      if (use_rst) begin
         rst = 1'b1;
         wait_clk(3);
         s_ce_n = 1'b1;
         wait_clk(6);
         rst = 1'b0;
         wait_clk(10);
      end else begin
         s_rst_n = 1'b0;
         wait_clk(32);
         s_rst_n = 1'b1;
         wait_clk(6);
         s_ce_n = 1'b1;
         wait_clk(10);
      end
      m_frame = '0; m_cw0 = '0; m_cw1 = '0;
      check_cleared(use_rst ? "abort_rst" : "abort_s_rst_n");
      fill_pattern(FB);
      run_load(1'b0, -1, lat);
      check_lat("after_abort", lat);
      check_drain("abort");
   endtask

   initial begin
      test_reset();
      test_cw();
      test_data();
      test_len();
      test_zero();
      test_proto();
      test_abort(1'b1);
      test_abort(1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
